// File: rtl/arith_unit_alu_pkg.sv
// Shared constants for the arithmetic unit: opcode encodings, widths, tags.
package arith_unit_alu_pkg;

   localparam int OPENUM_W = 6;
   localparam int ROB_ID_W = 4;
   localparam int DATA_W   = 32;
   localparam int ADDR_W   = 32;

   localparam logic TRUE  = 1'b1;
   localparam logic FALSE = 1'b0;

   localparam logic [ROB_ID_W-1:0] ZERO_ROB = '0;

   typedef enum logic [OPENUM_W-1:0] {
      OP_NOP   = 6'd0,
      OP_LUI   = 6'd1,
      OP_AUIPC = 6'd2,
      OP_JAL   = 6'd3,
      OP_JALR  = 6'd4,
      OP_BEQ   = 6'd5,
      OP_BNE   = 6'd6,
      OP_BLT   = 6'd7,
      OP_BGE   = 6'd8,
      OP_BLTU  = 6'd9,
      OP_BGEU  = 6'd10,
      OP_ADDI  = 6'd11,
      OP_SLTI  = 6'd12,
      OP_SLTIU = 6'd13,
      OP_XORI  = 6'd14,
      OP_ORI   = 6'd15,
      OP_ANDI  = 6'd16,
      OP_SLLI  = 6'd17,
      OP_SRLI  = 6'd18,
      OP_SRAI  = 6'd19,
      OP_ADD   = 6'd20,
      OP_SUB   = 6'd21,
      OP_SLL   = 6'd22,
      OP_SLT   = 6'd23,
      OP_SLTU  = 6'd24,
      OP_XOR   = 6'd25,
      OP_SRL   = 6'd26,
      OP_SRA   = 6'd27,
      OP_OR    = 6'd28,
      OP_AND   = 6'd29
   } openum_e;

   localparam openum_e OPENUM_NOP = OP_NOP;

endpackage

// File: rtl/arith_unit_alu_core.sv
// Combinational ALU datapath: (openum, V1, V2, imm, pc) -> (result, target, jump).
import arith_unit_alu_pkg::*;

module alu_core #(
   parameter int DATA_WIDTH = DATA_W,
   parameter int ADDR_WIDTH = ADDR_W
) (
   input  openum_e                 openum,
   input  logic [DATA_WIDTH-1:0]   v1,
   input  logic [DATA_WIDTH-1:0]   v2,
   input  logic [DATA_WIDTH-1:0]   imm,
   input  logic [ADDR_WIDTH-1:0]   pc,
   output logic [DATA_WIDTH-1:0]   result,
   output logic [ADDR_WIDTH-1:0]   target,
   output logic                    jump
);

   logic [4:0]            shamt_r;
   logic [4:0]            shamt_i;
   logic [ADDR_WIDTH-1:0] pc_imm;
   logic [ADDR_WIDTH-1:0] pc_4;
   logic [ADDR_WIDTH-1:0] jalr_sum;
   logic                  lt_s;
   logic                  lt_u;
   logic                  lt_si;
   logic                  lt_ui;
   logic                  eq;

   assign shamt_r  = v2[4:0];
   assign shamt_i  = imm[4:0];
   assign pc_imm   = pc + ADDR_WIDTH'(imm);
   assign pc_4     = pc + ADDR_WIDTH'(4);
   assign jalr_sum = ADDR_WIDTH'(v1 + imm);
   assign lt_s     = $signed(v1) < $signed(v2);
   assign lt_u     = v1 < v2;
   assign lt_si    = $signed(v1) < $signed(imm);
   assign lt_ui    = v1 < imm;
   assign eq       = v1 == v2;

   // Operation decode; unknown opcodes fall through to all-zero outputs.
   always_comb begin
      result = '0;
      target = '0;
      jump   = FALSE;
      case (openum)
         OP_ADD:   result = v1 + v2;
         OP_SUB:   result = v1 - v2;
         OP_AND:   result = v1 & v2;
         OP_OR:    result = v1 | v2;
         OP_XOR:   result = v1 ^ v2;
         OP_SLL:   result = v1 << shamt_r;
         OP_SRL:   result = v1 >> shamt_r;
         OP_SRA:   result = $signed(v1) >>> shamt_r;
         OP_SLT:   result = DATA_WIDTH'(lt_s);
         OP_SLTU:  result = DATA_WIDTH'(lt_u);
         OP_ADDI:  result = v1 + imm;
         OP_ANDI:  result = v1 & imm;
         OP_ORI:   result = v1 | imm;
         OP_XORI:  result = v1 ^ imm;
         OP_SLTI:  result = DATA_WIDTH'(lt_si);
         OP_SLTIU: result = DATA_WIDTH'(lt_ui);
         OP_SLLI:  result = v1 << shamt_i;
         OP_SRLI:  result = v1 >> shamt_i;
         OP_SRAI:  result = $signed(v1) >>> shamt_i;
         OP_LUI:   result = imm;
         OP_AUIPC: result = DATA_WIDTH'(pc_imm);
         OP_JAL: begin
            result = DATA_WIDTH'(pc_4);
            target = pc_imm;
            jump   = TRUE;
         end
         OP_JALR: begin
            result = DATA_WIDTH'(pc_4);
            target = jalr_sum & ~ADDR_WIDTH'(1);
            jump   = TRUE;
         end
         OP_BEQ:  begin target = pc_imm; jump = eq;    end
         OP_BNE:  begin target = pc_imm; jump = !eq;   end
         OP_BLT:  begin target = pc_imm; jump = lt_s;  end
         OP_BGE:  begin target = pc_imm; jump = !lt_s; end
         OP_BLTU: begin target = pc_imm; jump = lt_u;  end
         OP_BGEU: begin target = pc_imm; jump = !lt_u; end
         default: ;
      endcase
   end

endmodule

// File: rtl/arith_unit_alu.sv
// Arithmetic functional unit: decodes an RS issue and broadcasts the
// registered result on the CDB one cycle later.
import arith_unit_alu_pkg::*;

module arith_unit_alu #(
   parameter int OPENUM_WIDTH = OPENUM_W,
   parameter int ROB_ID_WIDTH = ROB_ID_W,
   parameter int DATA_WIDTH   = DATA_W,
   parameter int ADDR_WIDTH   = ADDR_W
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    rdy,
   input  logic                    misbranch_flag,
   input  logic [OPENUM_WIDTH-1:0] openum_from_rs,
   input  logic [DATA_WIDTH-1:0]   V1_from_rs,
   input  logic [DATA_WIDTH-1:0]   V2_from_rs,
   input  logic [DATA_WIDTH-1:0]   imm_from_rs,
   input  logic [ADDR_WIDTH-1:0]   pc_from_rs,
   input  logic [ROB_ID_WIDTH-1:0] rob_id_from_rs,
   output logic                    valid_to_cdb,
   output logic [ROB_ID_WIDTH-1:0] rob_id_to_cdb,
   output logic [DATA_WIDTH-1:0]   result_to_cdb,
   output logic [ADDR_WIDTH-1:0]   target_pc_to_cdb,
   output logic                    jump_flag_to_cdb
);

   logic [OPENUM_W-1:0]   openum_bits;
   openum_e               openum;
   logic                  issue;
   logic [DATA_WIDTH-1:0] alu_result;
   logic [ADDR_WIDTH-1:0] alu_target;
   logic                  alu_jump;

   assign openum_bits = openum_from_rs[OPENUM_W-1:0];
   assign openum      = openum_e'(openum_bits);
   assign issue       = (openum != OPENUM_NOP);

   alu_core #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_alu_core (
      .openum (openum),
      .v1     (V1_from_rs),
      .v2     (V2_from_rs),
      .imm    (imm_from_rs),
      .pc     (pc_from_rs),
      .result (alu_result),
      .target (alu_target),
      .jump   (alu_jump)
   );

   // CDB output register: reset beats flush beats issue; rdy low freezes all.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_to_cdb     <= FALSE;
         rob_id_to_cdb    <= ROB_ID_WIDTH'(ZERO_ROB);
         result_to_cdb    <= '0;
         target_pc_to_cdb <= '0;
         jump_flag_to_cdb <= FALSE;
      end else if (rdy) begin
         if (issue && !misbranch_flag) begin
            valid_to_cdb     <= TRUE;
            rob_id_to_cdb    <= rob_id_from_rs;
            result_to_cdb    <= alu_result;
            target_pc_to_cdb <= alu_target;
            jump_flag_to_cdb <= alu_jump;
         end else begin
            valid_to_cdb     <= FALSE;
            rob_id_to_cdb    <= ROB_ID_WIDTH'(ZERO_ROB);
            result_to_cdb    <= '0;
            target_pc_to_cdb <= '0;
            jump_flag_to_cdb <= FALSE;
         end
      end
   end

endmodule

// File: tb/tb_arith_unit_alu.sv
// Scoreboard bench for arith_unit_alu: driver queues the hand-computed CDB
// state expected after each edge, monitor compares on the falling edge.
import arith_unit_alu_pkg::*;

module tb_arith_unit_alu;

   typedef struct {
      logic        v;
      logic [3:0]  rob;
      logic [31:0] res;
      logic [31:0] tgt;
      logic        jmp;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rdy = 1'b0;
   logic        misbranch_flag = 1'b0;
   logic [5:0]  openum_from_rs = '0;
   logic [31:0] V1_from_rs = '0;
   logic [31:0] V2_from_rs = '0;
   logic [31:0] imm_from_rs = '0;
   logic [31:0] pc_from_rs = '0;
   logic [3:0]  rob_id_from_rs = '0;
   logic        valid_to_cdb;
   logic [3:0]  rob_id_to_cdb;
   logic [31:0] result_to_cdb;
   logic [31:0] target_pc_to_cdb;
   logic        jump_flag_to_cdb;

   exp_t q[$];
   exp_t last;
   int   tests = 0;
   int   fails = 0;

   arith_unit_alu dut (
      .clk              (clk),
      .rst              (rst),
      .rdy              (rdy),
      .misbranch_flag   (misbranch_flag),
      .openum_from_rs   (openum_from_rs),
      .V1_from_rs       (V1_from_rs),
      .V2_from_rs       (V2_from_rs),
      .imm_from_rs      (imm_from_rs),
      .pc_from_rs       (pc_from_rs),
      .rob_id_from_rs   (rob_id_from_rs),
      .valid_to_cdb     (valid_to_cdb),
      .rob_id_to_cdb    (rob_id_to_cdb),
      .result_to_cdb    (result_to_cdb),
      .target_pc_to_cdb (target_pc_to_cdb),
      .jump_flag_to_cdb (jump_flag_to_cdb)
   );

   always #5 clk = ~clk;

   function automatic exp_t mk(input logic v, input logic [3:0] rob,
                               input logic [31:0] res, input logic [31:0] tgt,
                               input logic jmp);
      exp_t e;
      e.v = v; e.rob = rob; e.res = res; e.tgt = tgt; e.jmp = jmp;
      return e;
   endfunction

   task automatic drive(input logic r, input logic rd, input logic mis,
                        input logic [5:0] op, input logic [31:0] v1,
                        input logic [31:0] v2, input logic [31:0] imm,
                        input logic [31:0] pc, input logic [3:0] rob,
                        input exp_t e);
      @(negedge clk);
      rst = r; rdy = rd; misbranch_flag = mis;
      openum_from_rs = op; V1_from_rs = v1; V2_from_rs = v2;
      imm_from_rs = imm; pc_from_rs = pc; rob_id_from_rs = rob;
      @(posedge clk);
      q.push_back(e);
      last = e;
   endtask

   task automatic iss(input logic [5:0] op, input logic [31:0] v1,
                      input logic [31:0] v2, input logic [31:0] imm,
                      input logic [31:0] pc, input logic [3:0] rob,
                      input logic [31:0] res, input logic [31:0] tgt,
                      input logic jmp);
      drive(1'b0, 1'b1, 1'b0, op, v1, v2, imm, pc, rob, mk(1'b1, rob, res, tgt, jmp));
   endtask

   task automatic idle();
      drive(1'b0, 1'b1, 1'b0, OP_NOP, 32'h0, 32'h0, 32'h0, 32'h0, 4'd0,
            mk(1'b0, 4'd0, 32'h0, 32'h0, 1'b0));
   endtask

   // Monitor: one queued expectation per clock edge, checked mid-cycle.
   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         tests++;
         if (valid_to_cdb !== e.v || rob_id_to_cdb !== e.rob ||
             result_to_cdb !== e.res || target_pc_to_cdb !== e.tgt ||
             jump_flag_to_cdb !== e.jmp) begin
            fails++;
            $display("FAIL cdb#%0d got v=%0b rob=%0d res=%h tgt=%h j=%0b required v=%0b rob=%0d res=%h tgt=%h j=%0b",
                     tests, valid_to_cdb, rob_id_to_cdb, result_to_cdb, target_pc_to_cdb,
                     jump_flag_to_cdb, e.v, e.rob, e.res, e.tgt, e.jmp);
         end
      end
   end

   initial begin
      exp_t zero;
      zero = mk(1'b0, 4'd0, 32'h0, 32'h0, 1'b0);

      // reset with rdy low, with an issue presented
      drive(1'b1, 1'b0, 1'b0, OP_ADD, 32'h1, 32'h1, 32'h0, 32'h0, 4'd9, zero);
      idle();

      // register-register
      iss(OP_ADD,  32'h7FFFFFFF, 32'h1, 32'h0, 32'h0, 4'd3, 32'h80000000, 32'h0, 1'b0);
      iss(OP_SUB,  32'd5, 32'd7, 32'h0, 32'h0, 4'd4, 32'hFFFFFFFE, 32'h0, 1'b0);
      iss(OP_AND,  32'hF0F0, 32'hFF00, 32'h0, 32'h0, 4'd5, 32'h0000F000, 32'h0, 1'b0);
      iss(OP_OR,   32'hF0F0, 32'hFF00, 32'h0, 32'h0, 4'd6, 32'h0000FFF0, 32'h0, 1'b0);
      iss(OP_XOR,  32'hF0F0, 32'hFF00, 32'h0, 32'h0, 4'd7, 32'h00000FF0, 32'h0, 1'b0);
      iss(OP_SLL,  32'h1, 32'h21, 32'h0, 32'h0, 4'd8, 32'h2, 32'h0, 1'b0);
      iss(OP_SRL,  32'h80000000, 32'd31, 32'h0, 32'h0, 4'd9, 32'h1, 32'h0, 1'b0);
      iss(OP_SRA,  32'h80000000, 32'd4, 32'h0, 32'h0, 4'd10, 32'hF8000000, 32'h0, 1'b0);
      iss(OP_SLTU, 32'hFFFFFFFF, 32'h1, 32'h0, 32'h0, 4'd11, 32'h0, 32'h0, 1'b0);
      iss(OP_SLT,  32'hFFFFFFFF, 32'h1, 32'h0, 32'h0, 4'd12, 32'h1, 32'h0, 1'b0);

      // immediate
      iss(OP_SRAI,  32'h80000000, 32'h0, 32'd4, 32'h0, 4'd1, 32'hF8000000, 32'h0, 1'b0);
      iss(OP_SLTI,  32'hFFFFFFFF, 32'h0, 32'h0, 32'h0, 4'd2, 32'h1, 32'h0, 1'b0);
      iss(OP_SLTIU, 32'hFFFFFFFF, 32'h0, 32'h1, 32'h0, 4'd3, 32'h0, 32'h0, 1'b0);
      iss(OP_ADDI,  32'd16, 32'h0, 32'hFFFFFFFF, 32'h0, 4'd4, 32'hF, 32'h0, 1'b0);
      iss(OP_ANDI,  32'h12345678, 32'h0, 32'hFF, 32'h0, 4'd5, 32'h78, 32'h0, 1'b0);
      iss(OP_ORI,   32'h12345678, 32'h0, 32'hFF, 32'h0, 4'd6, 32'h123456FF, 32'h0, 1'b0);
      iss(OP_XORI,  32'h12345678, 32'h0, 32'hFF, 32'h0, 4'd7, 32'h12345687, 32'h0, 1'b0);
      iss(OP_SLLI,  32'h3, 32'h0, 32'h4, 32'h0, 4'd8, 32'h30, 32'h0, 1'b0);
      iss(OP_SRLI,  32'hF0, 32'h0, 32'h4, 32'h0, 4'd9, 32'hF, 32'h0, 1'b0);
      iss(OP_LUI,   32'h0, 32'h0, 32'h12345000, 32'h0, 4'd10, 32'h12345000, 32'h0, 1'b0);
      iss(OP_AUIPC, 32'h0, 32'h0, 32'h2000, 32'h1000, 4'd11, 32'h3000, 32'h0, 1'b0);

      // jumps and branches
      iss(OP_JAL,  32'h0, 32'h0, 32'h40, 32'h100, 4'd12, 32'h104, 32'h140, 1'b1);
      iss(OP_JALR, 32'h1003, 32'h0, 32'h4, 32'h100, 4'd13, 32'h104, 32'h1006, 1'b1);
      iss(OP_BEQ,  32'd5, 32'd5, 32'h8, 32'h20, 4'd1, 32'h0, 32'h28, 1'b1);
      iss(OP_BNE,  32'd5, 32'd5, 32'h8, 32'h20, 4'd2, 32'h0, 32'h28, 1'b0);
      iss(OP_BLT,  32'hFFFFFFFF, 32'h0, 32'hFFFFFFF8, 32'h20, 4'd3, 32'h0, 32'h18, 1'b1);
      iss(OP_BGE,  32'hFFFFFFFF, 32'h0, 32'hFFFFFFF8, 32'h20, 4'd4, 32'h0, 32'h18, 1'b0);
      iss(OP_BLTU, 32'hFFFFFFFF, 32'h0, 32'hFFFFFFF8, 32'h20, 4'd5, 32'h0, 32'h18, 1'b0);
      iss(OP_BGEU, 32'hFFFFFFFF, 32'h0, 32'hFFFFFFF8, 32'h20, 4'd6, 32'h0, 32'h18, 1'b1);

      // unknown opcode still completes
      iss(6'd63, 32'h5, 32'h5, 32'h5, 32'h5, 4'd7, 32'h0, 32'h0, 1'b0);
      idle();

      // back-to-back
      iss(OP_ADDI, 32'h0, 32'h0, 32'd1, 32'h0, 4'd1, 32'd1, 32'h0, 1'b0);
      iss(OP_ADDI, 32'h0, 32'h0, 32'd2, 32'h0, 4'd2, 32'd2, 32'h0, 1'b0);
      iss(OP_ADDI, 32'h0, 32'h0, 32'd3, 32'h0, 4'd3, 32'd3, 32'h0, 1'b0);

      // rdy stall after the first of three; stalled inputs are ignored
      iss(OP_ADDI, 32'h0, 32'h0, 32'd1, 32'h0, 4'd1, 32'd1, 32'h0, 1'b0);
      drive(1'b0, 1'b0, 1'b0, OP_ADDI, 32'h0, 32'h0, 32'd2, 32'h0, 4'd2, last);
      drive(1'b0, 1'b0, 1'b1, OP_NOP, 32'h0, 32'h0, 32'd0, 32'h0, 4'd0, last);
      iss(OP_ADDI, 32'h0, 32'h0, 32'd2, 32'h0, 4'd2, 32'd2, 32'h0, 1'b0);
      iss(OP_ADDI, 32'h0, 32'h0, 32'd3, 32'h0, 4'd3, 32'd3, 32'h0, 1'b0);

      // flush beats issue
      drive(1'b0, 1'b1, 1'b1, OP_ADD, 32'h1, 32'h2, 32'h0, 32'h0, 4'd5, zero);
      iss(OP_ADD, 32'h1, 32'h2, 32'h0, 32'h0, 4'd6, 32'h3, 32'h0, 1'b0);

      // reset mid-stream, then first issue after release
      drive(1'b1, 1'b1, 1'b0, OP_ADD, 32'h1, 32'h2, 32'h0, 32'h0, 4'd7, zero);
      iss(OP_SUB, 32'h9, 32'h2, 32'h0, 32'h0, 4'd8, 32'h7, 32'h0, 1'b0);

      // reset together with flush, and reset while stalled
      drive(1'b1, 1'b1, 1'b1, OP_ADD, 32'h1, 32'h2, 32'h0, 32'h0, 4'd9, zero);
      iss(OP_JAL, 32'h0, 32'h0, 32'h8, 32'h10, 4'd10, 32'h14, 32'h18, 1'b1);
      drive(1'b1, 1'b0, 1'b0, OP_NOP, 32'h0, 32'h0, 32'h0, 32'h0, 4'd0, zero);
      idle();

      for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
      @(negedge clk);
      if (q.size() != 0) begin
         fails++;
         $display("FAIL drain got %0d pending required 0", q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/arith_unit_alu.md
ARITH_UNIT_ALU -- requirements
Module: arith_unit_alu

Interface
REQ-001 The block SHALL have these parameters and constants (name, default, meaning):
- OPENUM_WIDTH, 6, opcode-enum width
- ROB_ID_WIDTH, 4, ROB tag width; tag 0 (ZERO_ROB) means "no tag"
- DATA_WIDTH, 32, operand and result width
- ADDR_WIDTH, 32, PC width

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk  in  1  single clock; all state updates on its rising edge
- rst  in  1  synchronous, active-high reset
- rdy  in  1  global enable; when low, all state SHALL hold
- misbranch_flag  in  1  flush request
- openum_from_rs  in  OPENUM_WIDTH  operation; OPENUM_NOP means no issue this cycle
- V1_from_rs  in  DATA_WIDTH  source operand 1
- V2_from_rs  in  DATA_WIDTH  source operand 2
- imm_from_rs  in  DATA_WIDTH  sign-extended immediate
- pc_from_rs  in  ADDR_WIDTH  PC of the instruction
- rob_id_from_rs  in  ROB_ID_WIDTH  destination ROB tag
- valid_to_cdb  out  1  Arith CDB broadcast valid
- rob_id_to_cdb  out  ROB_ID_WIDTH  tag of the broadcast result
- result_to_cdb  out  DATA_WIDTH  value written to rd
- target_pc_to_cdb  out  ADDR_WIDTH  resolved jump/branch target
- jump_flag_to_cdb  out  1  control transfer taken

Function
REQ-003 An issue SHALL occur when openum_from_rs != OPENUM_NOP, rdy=1, rst=0 and misbranch_flag=0.
REQ-004 An issue SHALL appear on the CDB outputs exactly one cycle later, registered (latency 1, throughput 1 per cycle, no back-pressure).
REQ-005 A cycle with no issue SHALL drive valid_to_cdb=0 in the following cycle; rob_id, result, target and jump SHALL also clear to 0.
REQ-006 Register-register ops (ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU) SHALL use V1 op V2; shift amount = V2[4:0].
REQ-007 Immediate ops (ADDI, ANDI, ORI, XORI, SLTI, SLTIU, SLLI, SRLI, SRAI) SHALL use V1 op imm; shift amount = imm[4:0].
REQ-008 Arithmetic SHALL be modulo 2^32 with no overflow flag; SLT/SRA SHALL be signed; SLTU/SLTIU SHALL be unsigned; compare results SHALL be 0 or 1.
REQ-009 LUI SHALL give result=imm; AUIPC SHALL give result=pc+imm; jump_flag=0 for both.
REQ-010 JAL SHALL give result=pc+4, target=pc+imm, jump_flag=1.
REQ-011 JALR SHALL give result=pc+4, target=(V1+imm) with bit0 cleared, jump_flag=1; it SHALL use V1 as sampled at issue even if the destination tag equals a source.
REQ-012 BEQ, BNE, BLT, BGE, BLTU, BGEU SHALL compare V1 with V2; target=pc+imm, jump_flag=condition, result=0.
REQ-013 Non-branch, non-jump ops SHALL give target=0 and jump_flag=0.
REQ-014 An unknown openum SHALL broadcast valid=1 with result=0, target=0 and jump_flag=0, so the ROB entry still completes.
REQ-015 misbranch_flag=1 SHALL, at that edge, drop any issue presented and clear valid_to_cdb; flush SHALL take priority over issue.
REQ-016 rdy=0 SHALL hold every output register unchanged and ignore inputs; rdy=1 SHALL resume with no lost or duplicated broadcast.
REQ-017 Simultaneous rst and misbranch_flag SHALL behave as reset.

Reset
REQ-018 On a rst=1 edge, all outputs SHALL become 0 (valid_to_cdb=0, rob_id_to_cdb=ZERO_ROB), whatever rdy is.
REQ-019 Reset asserted mid-stream SHALL discard the issue presented at that edge; the first broadcast after release SHALL come from the first issue at rst=0.

Structure
REQ-020 The openum encodings, OPENUM_NOP, ZERO_ROB, the width macros and TRUE/FALSE SHALL live in the shared constant include and SHALL NOT be redefined locally.
REQ-021 The block SHALL contain one combinational sub-module, alu_core, mapping (openum, V1, V2, imm, pc) to (result, target, jump), plus a single output register stage in the top.

Verification
REQ-022 ADD with V1=0x7FFFFFFF, V2=1, rob 3 -> next cycle valid=1, rob=3, result=0x80000000, jump=0.
REQ-023 SRAI with V1=0x80000000, imm=4 -> result 0xF8000000; SLTU with 0xFFFFFFFF vs 1 -> result 0; SLT with the same operands -> result 1.
REQ-024 JALR with pc=0x100, V1=0x1003, imm=4 -> result 0x104, target 0x1006, jump=1; BGE with -1 vs 0 (pc=0x20, imm=-8) -> jump=0, target 0x18.
REQ-025 Back-to-back ADDI issues with rob 1,2,3 on consecutive cycles -> three consecutive broadcasts with tags 1,2,3; rdy held low for 2 cycles after the first -> its broadcast held stable and nothing lost.
REQ-026 Issue rob 5 with misbranch_flag=1 at the same edge -> valid_to_cdb=0 next cycle; rst pulse during a stream -> all outputs 0 next cycle.
